ru_array: RTL

RU_ARRAY -- requirements
Module: ru_array

---
 rtl/ru_array.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ru_array.sv
// ru_array: per-lane exp/pow2 unit, y = (in_1 - log2(in_0) or in_0) * K, out_1 = 2^y (Mitchell approx).
// Latency: 4 cycles after the accepting edge (input capture + log2, subtract, scale, pow2 stages).
// Backpressure: ready_in = !valid_out || ready_out; when low, every stage register holds its beat.
module ru_array #(
  parameter int                DATA_W = 16,
  parameter int                FRAC_W = 10,
  parameter int                LANES  = 2,
  parameter logic [DATA_W-1:0] LOG2E  = DATA_W'(16'h05C4)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel_mult,
  input  logic                    sel_mux,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_W-1:0]       in_0,
  input  logic [LANES*DATA_W-1:0] in_1,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [LANES*DATA_W-1:0] out_0,
  output logic [LANES*DATA_W-1:0] out_1,
  output logic                    err
);

  // Intermediate arithmetic is done wide enough that products and shifts never wrap
  // before saturation back to a DATA_W word.
  localparam int WW = 2*DATA_W + 2;
  typedef logic signed [WW-1:0]     wide_t;
  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic [LANES*DATA_W-1:0]  vec_t;

  localparam word_t SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam word_t SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam word_t ONE  = word_t'(1) << FRAC_W;
  localparam word_t KLOG = LOG2E;

  function automatic word_t sat(input wide_t v);
    if (v > wide_t'(SMAX)) return SMAX;
    if (v < wide_t'(SMIN)) return SMIN;
    return word_t'(v);
  endfunction

  logic advance;

  // stage 0: captured input beat
  logic  s0_vld_q, s0_mult_q, s0_mux_q;
  word_t s0_in0_q;
  vec_t  s0_in1_q;

  // stage 1: log2(in_0)
  logic              s1_vld_q, s1_mult_q, s1_mux_q, s1_err_q, s1_err_d;
  word_t             s1_in0_q, s1_l_q, s1_l_d;
  vec_t              s1_in1_q;
  int                s1_p;
  logic [FRAC_W-1:0] s1_frac;
  wide_t             s1_lw;

  // stage 2: per-lane difference
  logic  s2_vld_q, s2_mult_q, s2_err_q;
  vec_t  s2_d_q, s2_d_d;
  word_t s2_sub;

  // stage 3: scaled exponent y
  logic  s3_vld_q, s3_err_q;
  vec_t  s3_y_q, s3_y_d;
  word_t s3_k;

  // stage 4: pow2 result, drives the outputs
  logic              s4_vld_q, s4_err_q;
  vec_t              s4_y_q, s4_p_q, s4_p_d;
  word_t             s4_y, s4_pw;
  int                s4_ip;
  logic [FRAC_W:0]   s4_mant;

  assign advance   = !s4_vld_q || ready_out;
  assign ready_in  = advance;
  assign valid_out = s4_vld_q;
  assign err       = s4_err_q;
  assign out_0     = s4_y_q;
  assign out_1     = s4_p_q;

  // Mitchell log2: integer part from the leading-one position, fraction from the bits below it
  always_comb begin
    s1_p = 0;
    for (int i = 0; i < DATA_W-1; i++) begin
      if (s0_in0_q[i]) s1_p = i;
    end
    // normalise the leading one to the MSB, then keep the FRAC_W bits under it
    s1_frac  = FRAC_W'((s0_in0_q << (DATA_W-1-s1_p)) >> (DATA_W-1-FRAC_W));
    s1_lw    = (wide_t'(s1_p - FRAC_W) <<< FRAC_W) + wide_t'(s1_frac);
    s1_err_d = !s0_mux_q && (s0_in0_q[DATA_W-1] || (s0_in0_q == '0));
    s1_l_d   = s1_err_d ? '0 : sat(s1_lw);
  end

  // subtract the shared operand (raw or its log2) from each lane, saturating
  always_comb begin
    s2_sub = s1_mux_q ? s1_in0_q : s1_l_q;
    s2_d_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_d_d[i*DATA_W +: DATA_W] =
        sat(wide_t'($signed(s1_in1_q[i*DATA_W +: DATA_W])) - wide_t'(s2_sub));
    end
  end

  // scale by log2(e) or 1.0; arithmetic shift floors negative products
  always_comb begin
    s3_k   = s2_mult_q ? KLOG : ONE;
    s3_y_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s3_y_d[i*DATA_W +: DATA_W] =
        sat((wide_t'($signed(s2_d_q[i*DATA_W +: DATA_W])) * wide_t'(s3_k)) >>> FRAC_W);
    end
  end

  // 2^y as (1.F) shifted by the integer part; errored beats report full scale
  always_comb begin
    s4_p_d  = '0;
    s4_y    = '0;
    s4_ip   = 0;
    s4_mant = '0;
    s4_pw   = '0;
    for (int i = 0; i < LANES; i++) begin
      s4_y    = $signed(s3_y_q[i*DATA_W +: DATA_W]);
      s4_ip   = int'(s4_y >>> FRAC_W);
      s4_mant = {1'b1, s4_y[FRAC_W-1:0]};
      if (s3_err_q || s4_ip >= DATA_W-1) begin
        s4_pw = SMAX;
      end else if (s4_ip >= 0) begin
        s4_pw = sat(wide_t'(s4_mant) << s4_ip);
      end else if (-s4_ip > FRAC_W+1) begin
        s4_pw = '0;
      end else begin
        s4_pw = word_t'(s4_mant >> (-s4_ip));
      end
      s4_p_d[i*DATA_W +: DATA_W] = s4_pw;
    end
  end

  // pipeline registers: every stage shifts together on advance, otherwise all hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vld_q  <= 1'b0;
      s0_mult_q <= 1'b0;
      s0_mux_q  <= 1'b0;
      s0_in0_q  <= '0;
      s0_in1_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_mult_q <= 1'b0;
      s1_mux_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_in0_q  <= '0;
      s1_l_q    <= '0;
      s1_in1_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_mult_q <= 1'b0;
      s2_err_q  <= 1'b0;
      s2_d_q    <= '0;
      s3_vld_q  <= 1'b0;
      s3_err_q  <= 1'b0;
      s3_y_q    <= '0;
      s4_vld_q  <= 1'b0;
      s4_err_q  <= 1'b0;
      s4_y_q    <= '0;
      s4_p_q    <= '0;
    end else if (advance) begin
      s0_vld_q  <= valid_in;
      s0_mult_q <= sel_mult;
      s0_mux_q  <= sel_mux;
      s0_in0_q  <= in_0;
      s0_in1_q  <= in_1;
      s1_vld_q  <= s0_vld_q;
      s1_mult_q <= s0_mult_q;
      s1_mux_q  <= s0_mux_q;
      s1_err_q  <= s1_err_d;
      s1_in0_q  <= s0_in0_q;
      s1_l_q    <= s1_l_d;
      s1_in1_q  <= s0_in1_q;
      s2_vld_q  <= s1_vld_q;
      s2_mult_q <= s1_mult_q;
      s2_err_q  <= s1_err_q;
      s2_d_q    <= s2_d_d;
      s3_vld_q  <= s2_vld_q;
      s3_err_q  <= s2_err_q;
      s3_y_q    <= s3_y_d;
      s4_vld_q  <= s3_vld_q;
      s4_err_q  <= s3_err_q;
      s4_y_q    <= s3_y_q;
      s4_p_q    <= s4_p_d;
    end
  end

endmodule
